// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending stores draining into data memory.
// Define STBUF_FWD_EN to forward matching store data to loads; otherwise matching loads stall.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_we,
  input  logic                   cpu_re,
  input  logic [31:0]            cpu_addr,
  input  logic [31:0]            cpu_wdata,
  output logic [31:0]            cpu_rdata,
  output logic                   cpu_stall,
  output logic [31:0]            mem_raddr,
  input  logic [31:0]            mem_rdata,
  output logic                   mem_we,
  output logic [31:0]            mem_waddr,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_ready,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [29:0]      addr_q [DEPTH];
  logic [29:0]      addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [AW-1:0]    off_s;
  logic [DEPTH-1:0] valid_s;
  logic [DEPTH-1:0] match_s;
  logic             hit_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;

  // Occupancy per physical slot and word-address match against the current load.
  always_comb begin
    valid_s = '0;
    match_s = '0;
    off_s   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off_s      = AW'(i) - head_q;
      valid_s[i] = ({1'b0, off_s} < count_q);
      match_s[i] = valid_s[i] && (addr_q[i] == cpu_addr[31:2]);
    end
    hit_s = |match_s;
  end

`ifdef STBUF_FWD_EN
  logic [AW-1:0] fwd_idx_s;
  logic [31:0]   fwd_data_s;

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_idx_s  = '0;
    fwd_data_s = 32'h0000_0000;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx_s = head_q + AW'(k);
      if (match_s[fwd_idx_s]) begin
        fwd_data_s = data_q[fwd_idx_s];
      end else begin
        fwd_data_s = fwd_data_s;
      end
    end
  end

  // Load data: forwarded store data on a hit, memory otherwise.
  always_comb begin
    if (cpu_re && hit_s) begin
      cpu_rdata = fwd_data_s;
    end else begin
      cpu_rdata = mem_rdata;
    end
  end
`else
  // Load data always comes from memory; hazards are resolved by stalling.
  always_comb begin
    cpu_rdata = mem_rdata;
  end
`endif

  // Handshakes, stall and next-state for pointers and occupancy.
  always_comb begin
    full_s    = (count_q == FULL_CNT);
    empty     = (count_q == CW'(0));
    count     = count_q;
    mem_raddr = cpu_addr;
    mem_we    = !empty;
    mem_waddr = {addr_q[head_q], 2'b00};
    mem_wdata = data_q[head_q];
    push_s    = cpu_we && !full_s;
    pop_s     = mem_we && mem_ready;
`ifdef STBUF_FWD_EN
    cpu_stall = cpu_we && full_s;
`else
    cpu_stall = (cpu_we && full_s) || (cpu_re && hit_s);
`endif
    if (push_s) begin
      tail_d = tail_q + AW'(1);
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      head_d = head_q + AW'(1);
    end else begin
      head_d = head_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry storage next-state: write the new store at the tail slot.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (push_s) begin
      addr_d[tail_q] = cpu_addr[31:2];
      data_d[tail_q] = cpu_wdata;
    end else begin
      addr_d[tail_q] = addr_q[tail_q];
      data_d[tail_q] = data_q[tail_q];
    end
  end

  // Control state; reset discards every pending store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset: only slots counted as valid are ever read.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of entries; a power of two, at least 2.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port cpu_we  in  1  the core issues a store this cycle.
REQ-005 SHALL have port cpu_re  in  1  the core issues a load this cycle.
REQ-006 SHALL have port cpu_addr  in  32  byte address from the core ALU output.
REQ-007 SHALL have port cpu_wdata  in  32  store data.
REQ-008 SHALL have port cpu_rdata  out  32  load data returned to the core.
REQ-009 SHALL have port cpu_stall  out  1  the core must hold its current instruction.
REQ-010 SHALL have port mem_raddr  out  32  data-memory read address, equal to cpu_addr combinationally.
REQ-011 SHALL have port mem_rdata  in  32  data-memory read data.
REQ-012 SHALL have port mem_we, mem_waddr, mem_wdata  out  1/32/32  data-memory write port.
REQ-013 SHALL have port mem_ready  in  1  data memory accepts the presented write this cycle.
REQ-014 SHALL have port empty  out  1  and port count  out  log2(DEPTH)+1  current occupancy.

Function
REQ-015 SHALL be a circular FIFO with head and tail pointers that wrap modulo DEPTH; each entry holds a word address (cpu_addr[31:2]) and 32-bit data.
REQ-016 SHALL enqueue {cpu_addr[31:2], cpu_wdata} at tail on a clock edge where cpu_we=1 and count<DEPTH.
REQ-017 SHALL assert cpu_stall combinationally when cpu_we=1 and count==DEPTH; a pop in the same cycle SHALL NOT cancel this stall.
REQ-018 SHALL drive mem_we=!empty, with mem_waddr={head_addr,2'b00} and mem_wdata=head_data.
REQ-019 SHALL pop the head on an edge where mem_we=1 and mem_ready=1.
REQ-020 SHALL leave count unchanged on an edge with a simultaneous enqueue and pop; otherwise count SHALL change by +1 or -1.
REQ-021 SHALL drain strictly in enqueue order, including repeated stores to the same address; entries SHALL NOT be coalesced.
REQ-022 SHALL compare load addresses on word address only (bits [31:2]).
REQ-023 SHALL drive cpu_rdata=mem_rdata when cpu_re=1 and no valid entry matches.
REQ-024 SHALL ignore cpu_re and cpu_we both high in one cycle; the core does not produce that combination.

Reset
REQ-025 SHALL, while reset=1, clear head, tail and count to 0; set empty=1 and mem_we=0; force cpu_stall=0.
REQ-026 SHALL discard all pending stores on reset asserted mid-drain; no store SHALL be written after reset rises.
REQ-027 SHALL NOT require entry data storage to be reset.

Configuration
REQ-028 SHALL, with macro STBUF_FWD_EN defined, return on a load the data of the youngest valid entry whose word address matches, combinationally and without stall.
REQ-029 SHALL, with STBUF_FWD_EN undefined, assert cpu_stall while cpu_re=1 and any valid entry matches; stall SHALL release the cycle after the last matching entry pops, and cpu_rdata SHALL then come from mem_rdata.

Verification
REQ-030 SHALL test basic drain: mem_ready=1, store 0x10<-5 -> mem_we=1 next cycle with mem_waddr=0x10, mem_wdata=5; empty=1 after the following edge.
REQ-031 SHALL test full plus stall: mem_ready=0, four stores to 0x0,0x4,0x8,0xC -> count=4; fifth store -> cpu_stall=1. Then mem_ready=1 -> drains in order 0x0,0x4,0x8,0xC; stalled store enqueues once count<4.
REQ-032 SHALL test forwarding with STBUF_FWD_EN: mem_ready=0, store 0x20<-7 then 0x20<-9, load 0x20 with mem_rdata=0 -> cpu_rdata=9, cpu_stall=0; load 0x22 -> also 9.
REQ-033 SHALL test forwarding disabled, without STBUF_FWD_EN: same stores, then load 0x20 -> cpu_stall=1 until both entries pop; memory then returns 9.
REQ-034 SHALL test wrap and simultaneous events: mem_ready=1, a store every cycle for 10 cycles -> count stays at 1; pointers wrap twice; memory holds all 10 values in order.
REQ-035 SHALL test reset mid-drain: three entries queued, mem_ready=0; reset pulsed -> count=0, empty=1, mem_we=0; no write occurs after mem_ready rises.
